// File: rtl/ngy_fb_reader_if.sv
// ngy_fb_reader_if -- SRAM access bus between the framebuffer line reader
// (master) and the SRAM arbiter / SRAM model (slave).
//
// Signals:
//   sram_req    master->slave  bus request to the arbiter
//   sram_gnt    slave->master  bus grant from the arbiter
//   sram_a      master->slave  17-bit SRAM word address
//   sram_dq_in  slave->master  16-bit SRAM read data
//   sram_oe_n   master->slave  output enable, active-low
//   sram_we_n   master->slave  write enable, active-low (reader never writes)
//   sram_ub_n   master->slave  upper byte enable, active-low
//   sram_lb_n   master->slave  lower byte enable, active-low
interface ngy_fb_reader_if;
    logic        sram_req;
    logic        sram_gnt;
    logic [16:0] sram_a;
    logic [15:0] sram_dq_in;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    modport master (
        output sram_req, sram_a, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        input  sram_gnt, sram_dq_in
    );

    modport slave (
        input  sram_req, sram_a, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        output sram_gnt, sram_dq_in
    );
endinterface

// File: rtl/ngy_fb_reader.sv
// ngy_fb_reader -- 1 bpp framebuffer scan-out reader.
//
// Two line buffers (front/back) of WPL = H_ACTIVE/16 words. The front buffer
// feeds pixel_state for the current scan position; while a line is shown the
// next framebuffer line is fetched from SRAM into the back buffer. A change of
// framebuffer line swaps the buffers and starts the next fetch.
//
// Optional feature: define NGY_FB_LINE_DOUBLE_EN to show every framebuffer
// line on two scan rows (fb_line = visible_y[9:1]).
//
// Ports:
//   clk_74a      sole clock, rising edge
//   reset        synchronous, active-high
//   visible_x    current scan column
//   visible_y    current scan row
//   pixel_state  registered framebuffer bit for (visible_x, visible_y)
//   fetch_busy   high while a line fetch is in progress
//   underrun     sticky: buffers swapped before the back-buffer fetch finished
//   sram         SRAM bus, master side (request/grant, address, data, strobes)
module ngy_fb_reader #(
    parameter logic [16:0] FB_BASE  = 17'h00000,
    parameter int          H_ACTIVE = 320,
    parameter int          V_ACTIVE = 240
) (
    input  logic                   clk_74a,
    input  logic                   reset,
    input  logic [9:0]             visible_x,
    input  logic [9:0]             visible_y,
    output logic                   pixel_state,
    output logic                   fetch_busy,
    output logic                   underrun,
    ngy_fb_reader_if.master        sram
);

    localparam int          WPL      = H_ACTIVE / 16;
    localparam int          IDX_W    = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPL - 1);
    localparam logic [16:0] WPL_A    = 17'(WPL);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [10:0] H_LIM    = 11'(H_ACTIVE);

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_ADDR, ST_WAIT, ST_CAP} state_t;

    state_t           state;
    logic [IDX_W-1:0] word_idx;
    logic [16:0]      line_base;
    logic [16:0]      sram_a_q;
    logic             req_q;
    logic             acc_n;        // shared oe/ub/lb strobe, active-low
    logic             front_sel;
    logic [1:0]       valid;
    logic [9:0]       fb_line_q;
    logic             boot;         // first cycle after reset: fetch line 0

    logic [15:0]      line_buf [2][WPL];

    // ---------------- framebuffer line selection ----------------
    logic [9:0] fb_line;
`ifdef NGY_FB_LINE_DOUBLE_EN
    assign fb_line = {1'b0, visible_y[9:1]};
`else
    assign fb_line = visible_y;
`endif

    logic        line_change;
    logic        line_in_range;
    logic [9:0]  target;
    logic        start_fetch;
    logic [16:0] start_base;
    logic        buf_we;

    assign line_change   = (fb_line != fb_line_q);
    assign line_in_range = (fb_line <= V_LAST);
    // Wraps to line 0 only from the last visible line; beyond it no fetch.
    assign target        = (fb_line == V_LAST) ? 10'd0 : fb_line + 10'd1;
    assign start_fetch   = line_change ? line_in_range : boot;
    assign start_base    = line_change ? FB_BASE + 17'(target) * WPL_A : FB_BASE;

    // A word is kept only if the grant survived to the end of CAP and the
    // fetch is not being aborted by a line change in the same cycle.
    assign buf_we = (state == ST_CAP) && sram.sram_gnt && !line_change && !reset;

    // ---------------- fetch FSM ----------------
    // NOTE: every register in a clocked block is assigned with <= so all
    // right-hand sides see pre-edge values regardless of statement order.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            state     <= ST_IDLE;
            word_idx  <= '0;
            line_base <= '0;
            sram_a_q  <= '0;
            req_q     <= 1'b0;
            acc_n     <= 1'b1;
            fetch_busy <= 1'b0;
            underrun  <= 1'b0;
            front_sel <= 1'b0;
            valid     <= 2'b00;
            fb_line_q <= fb_line;
            boot      <= 1'b1;
        end else if (line_change || boot) begin
            boot      <= 1'b0;
            fb_line_q <= fb_line;
            if (line_change) begin
                front_sel        <= ~front_sel;
                valid[front_sel] <= 1'b0;        // old front becomes new back
                if (state != ST_IDLE)
                    underrun <= 1'b1;
            end
            word_idx   <= '0;
            line_base  <= start_base;
            acc_n      <= 1'b1;
            state      <= start_fetch ? ST_REQ : ST_IDLE;
            req_q      <= start_fetch;
            fetch_busy <= start_fetch;
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_REQ: begin
                    if (sram.sram_gnt) begin
                        state    <= ST_ADDR;
                        sram_a_q <= line_base + 17'(word_idx);
                        acc_n    <= 1'b0;
                    end
                end
                ST_ADDR, ST_WAIT: begin
                    if (!sram.sram_gnt) begin
                        state <= ST_REQ;
                        acc_n <= 1'b1;
                    end else begin
                        state <= (state == ST_ADDR) ? ST_WAIT : ST_CAP;
                    end
                end
                ST_CAP: begin
                    if (!sram.sram_gnt) begin
                        state <= ST_REQ;          // same word re-read on regrant
                        acc_n <= 1'b1;
                    end else if (word_idx == LAST_IDX) begin
                        state             <= ST_IDLE;
                        valid[~front_sel] <= 1'b1;
                        req_q             <= 1'b0;
                        fetch_busy        <= 1'b0;
                        acc_n             <= 1'b1;
                    end else begin
                        state    <= ST_ADDR;
                        word_idx <= word_idx + 1'b1;
                        sram_a_q <= line_base + 17'(word_idx) + 17'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the line buffers are plain storage with no reset; the valid bits
    // alone decide whether their contents are shown.
    always_ff @(posedge clk_74a) begin
        if (buf_we)
            line_buf[~front_sel][word_idx] <= sram.sram_dq_in;
    end

    // ---------------- pixel output ----------------
    logic             px_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic [15:0]      rd_word;

    assign px_in_range = ({1'b0, visible_x} < H_LIM) && line_in_range;
    // In range, visible_x[9:4] < WPL so its low IDX_W bits are the full index.
    assign rd_idx      = px_in_range ? visible_x[4 +: IDX_W] : '0;
    assign rd_word     = line_buf[front_sel][rd_idx];

    always_ff @(posedge clk_74a) begin
        if (reset)
            pixel_state <= 1'b0;
        else
            pixel_state <= px_in_range && valid[front_sel]
                           && rd_word[4'd15 - visible_x[3:0]];
    end

    // ---------------- SRAM bus ----------------
    assign sram.sram_req  = req_q;
    assign sram.sram_a    = sram_a_q;
    assign sram.sram_oe_n = acc_n;
    assign sram.sram_ub_n = acc_n;
    assign sram.sram_lb_n = acc_n;
    assign sram.sram_we_n = 1'b1;

endmodule

// File: doc/ngy_fb_reader.md
NGY_FB_READER -- requirements
Module: ngy_fb_reader

Interface
REQ-001 Parameter FB_BASE, default 17'h00000: SRAM word address of framebuffer line 0.
REQ-002 Parameter H_ACTIVE, default 320: pixels per line, multiple of 16; WPL = H_ACTIVE/16 words per line.
REQ-003 Parameter V_ACTIVE, default 240: framebuffer lines.
REQ-004 clk_74a  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 visible_x  in  10  current scan pixel column from vga_controller.
REQ-007 visible_y  in  10  current scan pixel row from vga_controller.
REQ-008 pixel_state  out  1  framebuffer bit for (visible_x, visible_y), registered.
REQ-009 sram_req  out  1  SRAM bus request to arbiter.
REQ-010 sram_gnt  in  1  SRAM bus grant from arbiter.
REQ-011 sram_a  out  17  SRAM word address.
REQ-012 sram_dq_in  in  16  SRAM read data.
REQ-013 sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low.
REQ-014 fetch_busy  out  1  high while a line fetch is in progress.
REQ-015 underrun  out  1  sticky: a buffer swap occurred before its fetch completed.

Function
REQ-016 Two line buffers of WPL x 16 bits (front, back), each with a valid bit; pixel_state reads front, fetch writes back.
REQ-017 fb_line = visible_y; fetch target = (fb_line + 1) mod V_ACTIVE.
REQ-018 On a change of fb_line (registered compare): swap front/back, clear new back valid, start fetch of target line into new back, abort any fetch in progress.
REQ-019 pixel_state, 1-cycle latency: bit 15 - visible_x[3:0] of front word visible_x[9:4]; 0 if front invalid, visible_x >= H_ACTIVE, or visible_y >= V_ACTIVE.
REQ-020 FSM states IDLE, REQ, ADDR, WAIT, CAP; IDLE -> REQ on fetch start; REQ -> ADDR when sram_gnt=1; ADDR -> WAIT -> CAP (one cycle each); CAP -> ADDR for next word, or -> IDLE after word WPL-1 with back valid set.
REQ-021 sram_a = FB_BASE + target*WPL + word index, 17-bit wrapping add; held constant ADDR through CAP; data sampled from sram_dq_in at end of CAP.
REQ-022 sram_oe_n, sram_ub_n, sram_lb_n low in ADDR/WAIT/CAP, high otherwise; sram_we_n constantly high.
REQ-023 sram_req high in REQ/ADDR/WAIT/CAP; if sram_gnt drops in ADDR/WAIT/CAP, current word discarded, FSM -> REQ, same word re-read after regrant.
REQ-024 Line change with fetch incomplete: underrun set to 1, new fetch starts per REQ-018 in the same cycle.
REQ-025 Line change with fb_line >= V_ACTIVE: swap still occurs; no fetch issued while fb_line+1 >= V_ACTIVE except target wraps to line 0 when fb_line = V_ACTIVE-1.
REQ-026 fetch_busy = 1 in any state except IDLE.

Reset
REQ-027 Reset: pixel_state 0, sram_req 0, all strobes high, sram_a 0, fetch_busy 0, underrun 0, both valid bits 0, FSM IDLE.
REQ-028 First cycle after reset release: fetch of line 0 into back buffer starts without waiting for a line change.
REQ-029 Reset mid-fetch terminates access immediately; buffer contents need not be cleared.

Configuration
REQ-030 Macro NGY_FB_LINE_DOUBLE_EN defined: fb_line = visible_y[9:1], each framebuffer line shown on two scan rows, swaps/fetches only on even rows; V_ACTIVE counts framebuffer lines.
REQ-031 Macro NGY_FB_LINE_DOUBLE_EN undefined: fb_line = visible_y per REQ-017.

Verification
REQ-032 Reset release, gnt tied 1, SRAM model word = address -> first fetch reads 17'h0..17'h13, fetch_busy low after 1+20x3 cycles (plus REQ cycle), back valid set.
REQ-033 Line 5 word 0 = 16'h8001, visible_y 4->5 after fetch done -> pixel_state 1 at x=0 and x=15, 0 at x=1..14, one cycle after x applied.
REQ-034 sram_gnt dropped 4 cycles during word 7 WAIT -> sram_a returns FB_BASE+target*20+7, no word skipped, underrun stays 0.
REQ-035 visible_y advanced 10 cycles after fetch start -> underrun 1, new fetch restarts at word 0, underrun holds until reset.
REQ-036 visible_x = 320 or visible_y = 240 -> pixel_state 0; visible_y 239->0 transition uses line 0 prefetched during row 239.
REQ-037 With NGY_FB_LINE_DOUBLE_EN: rows 10 and 11 both show framebuffer line 5; exactly one fetch issued per row pair.
